// File: rtl/jtkunio_gfx_arb_if.sv
// jtkunio_gfx_arb_if: scroll/object client handshakes and the shared ROM read port
interface jtkunio_gfx_arb_if #(
    parameter int SCR_AW = 17,
    parameter int OBJ_AW = 17,
    parameter int ROM_AW = 18
);
    logic [SCR_AW-1:0] scr_addr;
    logic              scr_cs;
    logic [31:0]       scr_data;
    logic              scr_ok;
    logic [OBJ_AW-1:0] obj_addr;
    logic              obj_cs;
    logic [31:0]       obj_data;
    logic              obj_ok;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_cs;
    logic [31:0]       rom_data;
    logic              rom_ok;

    modport master (
        output scr_addr, scr_cs, obj_addr, obj_cs, rom_data, rom_ok,
        input  scr_data, scr_ok, obj_data, obj_ok, rom_addr, rom_cs
    );

    modport slave (
        input  scr_addr, scr_cs, obj_addr, obj_cs, rom_data, rom_ok,
        output scr_data, scr_ok, obj_data, obj_ok, rom_addr, rom_cs
    );
endinterface

// File: rtl/jtkunio_gfx_arb.sv
// jtkunio_gfx_arb: shares one 32-bit graphics ROM read slot between scroll (priority) and object fetchers
// Optional: define JTKUNIO_ARB_STATS_EN to add stat_maxwait, the longest wait any client saw before a grant
module jtkunio_gfx_arb #(
    parameter int                SCR_AW     = 17,
    parameter int                OBJ_AW     = 17,
    parameter int                ROM_AW     = 18,
    parameter logic [ROM_AW-1:0] OBJ_OFFSET = 18'h20000,
    parameter int                MAXSCR     = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef JTKUNIO_ARB_STATS_EN
    output logic [7:0] stat_maxwait,
`endif
    jtkunio_gfx_arb_if.slave bus
);
    localparam int AW = SCR_AW > OBJ_AW ? SCR_AW : OBJ_AW;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nx;
    logic              owner;
    logic [AW-1:0]     cap_addr;
    logic [SCR_AW-1:0] scr_tag;
    logic [OBJ_AW-1:0] obj_tag;
    logic              scr_tv, obj_tv;
    logic [3:0]        fair_cnt;
    logic              scr_pend, obj_pend, gnt_scr, gnt_obj, done;

    assign bus.scr_ok = bus.scr_cs & scr_tv & (bus.scr_addr == scr_tag);
    assign bus.obj_ok = bus.obj_cs & obj_tv & (bus.obj_addr == obj_tag);
    assign scr_pend   = bus.scr_cs & ~bus.scr_ok;
    assign obj_pend   = bus.obj_cs & ~bus.obj_ok;

    // Grant decision and next state; ISSUE always lasts one cycle so a stale rom_ok is never taken
    always_comb begin
        gnt_scr  = state == IDLE && scr_pend && (!obj_pend || fair_cnt < 4'(MAXSCR));
        gnt_obj  = state == IDLE && obj_pend && !gnt_scr;
        done     = state == WAIT && bus.rom_ok;
        state_nx = state;
        case (state)
            IDLE:    if (gnt_scr || gnt_obj) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.rom_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // Downstream request, per-client data/tags, and the object-starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rom_addr <= '0;
            bus.rom_cs   <= 1'b0;
            bus.scr_data <= '0;
            bus.obj_data <= '0;
            owner        <= 1'b0;
            cap_addr     <= '0;
            scr_tag      <= '0;
            obj_tag      <= '0;
            scr_tv       <= 1'b0;
            obj_tv       <= 1'b0;
            fair_cnt     <= '0;
        end else begin
            if (gnt_scr || gnt_obj) begin
                bus.rom_addr <= gnt_obj ? ROM_AW'(bus.obj_addr) + OBJ_OFFSET : ROM_AW'(bus.scr_addr);
                cap_addr     <= gnt_obj ? AW'(bus.obj_addr) : AW'(bus.scr_addr);
                owner        <= gnt_obj;
                bus.rom_cs   <= 1'b1;
            end
            if (done) begin
                bus.rom_cs <= 1'b0;
                if (owner) begin
                    bus.obj_data <= bus.rom_data;
                    obj_tag      <= cap_addr[OBJ_AW-1:0];
                    obj_tv       <= 1'b1;
                end else begin
                    bus.scr_data <= bus.rom_data;
                    scr_tag      <= cap_addr[SCR_AW-1:0];
                    scr_tv       <= 1'b1;
                end
            end
            fair_cnt <= !obj_pend || gnt_obj ? 4'd0 :
                        gnt_scr && fair_cnt < 4'(MAXSCR) ? fair_cnt + 4'd1 : fair_cnt;
        end
    end

`ifdef JTKUNIO_ARB_STATS_EN
    logic [7:0] scr_w, obj_w;
    logic       scr_busy, obj_busy;

    assign scr_busy = state != IDLE && !owner;
    assign obj_busy = state != IDLE && owner;

    // Wait counters freeze while the client's own access is in flight; the max is taken at grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_w        <= '0;
            obj_w        <= '0;
            stat_maxwait <= '0;
        end else begin
            scr_w <= !scr_pend || gnt_scr ? 8'd0 : scr_busy || &scr_w ? scr_w : scr_w + 8'd1;
            obj_w <= !obj_pend || gnt_obj ? 8'd0 : obj_busy || &obj_w ? obj_w : obj_w + 8'd1;
            stat_maxwait <= gnt_scr && scr_w > stat_maxwait ? scr_w :
                            gnt_obj && obj_w > stat_maxwait ? obj_w : stat_maxwait;
        end
    end
`endif
endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// tb_jtkunio_gfx_arb: vector table, hand-written corner sequences and a randomized ROM/client scoreboard
module tb_jtkunio_gfx_arb;
    localparam logic [17:0] OFS = 18'h20000;
    localparam int          LIM = 80;

    typedef struct {
        logic        scs;
        logic [16:0] sa;
        logic        rok;
        logic [31:0] rd;
        logic        ecs;
        logic [17:0] ea;
        logic        eok;
        logic [31:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    bit          rom_auto = 1'b0;
    logic [17:0] last_addr;
    int          lat, need;
    logic        prev_cs = 1'b0;
    logic [17:0] grants[$];
    vec_t        tbl[15];

    jtkunio_gfx_arb_if #(.SCR_AW(17), .OBJ_AW(17), .ROM_AW(18)) bus();

`ifdef JTKUNIO_ARB_STATS_EN
    logic [7:0] stat_maxwait;
`endif

    jtkunio_gfx_arb #(
        .SCR_AW(17), .OBJ_AW(17), .ROM_AW(18), .OBJ_OFFSET(18'h20000), .MAXSCR(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef JTKUNIO_ARB_STATS_EN
        .stat_maxwait(stat_maxwait),
`endif
        .bus(bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] h(input logic [17:0] a);
        return 32'(a) * 32'h9E3779B1;
    endfunction

    function automatic logic [16:0] pick();
        return $urandom_range(0, 7) == 0 ? 17'($urandom) : 17'($urandom_range(0, 11));
    endfunction

    // ROM model: data for an address shows up after a random latency; for one cycle after an
    // address change the previous ok/data are still presented (stale)
    task automatic rom_step();
        if (bus.rom_addr != last_addr) begin
            last_addr = bus.rom_addr;
            lat = 0;
        end else begin
            lat++;
            bus.rom_data = h(bus.rom_addr);
            bus.rom_ok   = bus.rom_cs ? lat >= need : 1'($urandom_range(0, 1));
            if (bus.rom_cs && bus.rom_ok) begin
                need = $urandom_range(1, 4);
                lat  = 0;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (rom_auto) rom_step();
        if (bus.rom_cs && !prev_cs) grants.push_back(bus.rom_addr);
        prev_cs = bus.rom_cs;
    endtask

    task automatic auto_on();
        rom_auto  = 1'b1;
        last_addr = bus.rom_addr;
        lat       = 0;
        need      = 2;
    endtask

    initial begin
        int idx, r, sw, ow;
        logic [17:0] exp_order[7];
        bus.scr_cs = 0; bus.scr_addr = '0; bus.obj_cs = 0; bus.obj_addr = '0;
        bus.rom_ok = 0; bus.rom_data = '0;
        repeat (3) cyc();
        chk("rst_rom_cs", 32'(bus.rom_cs), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_scr_data", bus.scr_data, 0);
        chk("rst_obj_data", bus.obj_data, 0);
        bus.scr_cs = 1; bus.obj_cs = 1;
        #1;
        chk("rst_scr_ok", 32'(bus.scr_ok), 0);
        chk("rst_obj_ok", 32'(bus.obj_ok), 0);
        bus.scr_cs = 0; bus.obj_cs = 0;
        rst_n = 1;

        tbl[0]  = '{1'b1, 17'h123, 1'b0, 32'h0,        1'b0, 18'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b1, 17'h123, 1'b0, 32'h0,        1'b1, 18'h123, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 17'h123, 1'b1, 32'hDEADBEEF, 1'b1, 18'h123, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 17'h123, 1'b0, 32'h0,        1'b0, 18'h123, 1'b1, 32'hDEADBEEF};
        tbl[4]  = tbl[3];
        tbl[5]  = tbl[3];
        tbl[6]  = tbl[3];
        tbl[7]  = '{1'b1, 17'h10,  1'b1, 32'h51510000, 1'b0, 18'h123, 1'b0, 32'hDEADBEEF};
        tbl[8]  = '{1'b1, 17'h10,  1'b1, 32'h51510000, 1'b1, 18'h10,  1'b0, 32'hDEADBEEF};
        tbl[9]  = '{1'b1, 17'h10,  1'b1, 32'h10000010, 1'b1, 18'h10,  1'b0, 32'hDEADBEEF};
        tbl[10] = '{1'b1, 17'h10,  1'b1, 32'h10000010, 1'b0, 18'h10,  1'b1, 32'h10000010};
        tbl[11] = '{1'b1, 17'h11,  1'b1, 32'h10000010, 1'b0, 18'h10,  1'b0, 32'h10000010};
        tbl[12] = '{1'b1, 17'h11,  1'b1, 32'h10000010, 1'b1, 18'h11,  1'b0, 32'h10000010};
        tbl[13] = '{1'b1, 17'h11,  1'b1, 32'h10000011, 1'b1, 18'h11,  1'b0, 32'h10000010};
        tbl[14] = '{1'b1, 17'h11,  1'b0, 32'h0,        1'b0, 18'h11,  1'b1, 32'h10000011};
        for (int i = 0; i < 15; i++) begin
            cyc();
            bus.scr_cs = tbl[i].scs; bus.scr_addr = tbl[i].sa;
            bus.rom_ok = tbl[i].rok; bus.rom_data = tbl[i].rd;
            #1;
            chk($sformatf("vec%0d_rom_cs", i), 32'(bus.rom_cs), 32'(tbl[i].ecs));
            chk($sformatf("vec%0d_rom_addr", i), 32'(bus.rom_addr), 32'(tbl[i].ea));
            chk($sformatf("vec%0d_scr_ok", i), 32'(bus.scr_ok), 32'(tbl[i].eok));
            chk($sformatf("vec%0d_scr_data", i), bus.scr_data, tbl[i].ed);
            chk($sformatf("vec%0d_obj_ok", i), 32'(bus.obj_ok), 0);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("hold_rom_cs", 32'(bus.rom_cs), 0);
            chk("hold_scr_ok", 32'(bus.scr_ok), 1);
        end

        auto_on();
        grants.delete();
        exp_order = '{18'h40, 18'h41, 18'h42, 18'h43, 18'h20005, 18'h44, 18'h45};
        bus.obj_cs = 1; bus.obj_addr = 17'h5; bus.scr_addr = 17'h40; idx = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (bus.scr_ok) begin
                idx++;
                if (idx < 6) bus.scr_addr = 17'h40 + 17'(idx);
                else bus.scr_cs = 0;
            end
            if (bus.obj_ok) bus.obj_cs = 0;
        end
        chk("fair_grant_count", grants.size(), 7);
        for (int i = 0; i < 7 && i < grants.size(); i++)
            chk($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));

        rom_auto = 0; bus.rom_ok = 0; bus.scr_cs = 0;
        bus.obj_cs = 1; bus.obj_addr = 17'h100;
        cyc();
        chk("wchg_rom_cs1", 32'(bus.rom_cs), 1);
        chk("wchg_rom_addr1", 32'(bus.rom_addr), 32'h20100);
        cyc();
        bus.obj_addr = 17'h200; bus.rom_ok = 1; bus.rom_data = 32'h0B100100;
        #1 chk("wchg_ok_in_wait", 32'(bus.obj_ok), 0);
        cyc();
        bus.rom_ok = 0;
        #1 chk("wchg_ok_old_tag", 32'(bus.obj_ok), 0);
        chk("wchg_rom_cs_rel", 32'(bus.rom_cs), 0);
        cyc();
        chk("wchg_rom_cs2", 32'(bus.rom_cs), 1);
        chk("wchg_rom_addr2", 32'(bus.rom_addr), 32'h20200);
        cyc();
        bus.rom_ok = 1; bus.rom_data = 32'h0B200200;
        cyc();
        bus.rom_ok = 0;
        #1 chk("wchg_obj_ok", 32'(bus.obj_ok), 1);
        chk("wchg_obj_data", bus.obj_data, 32'h0B200200);

        bus.scr_cs = 1; bus.scr_addr = 17'h77;
        cyc();
        cyc();
        rst_n = 0;
        #1;
        chk("rmid_rom_cs", 32'(bus.rom_cs), 0);
        chk("rmid_scr_ok", 32'(bus.scr_ok), 0);
        chk("rmid_obj_ok", 32'(bus.obj_ok), 0);
        chk("rmid_scr_data", bus.scr_data, 0);
        chk("rmid_obj_data", bus.obj_data, 0);
        bus.obj_cs = 0;
        cyc();
        cyc();
        rst_n = 1;
        cyc();
        chk("rmid_refetch_cs", 32'(bus.rom_cs), 1);
        chk("rmid_refetch_addr", 32'(bus.rom_addr), 32'h77);
        cyc();
        bus.rom_ok = 1; bus.rom_data = 32'h77777777;
        cyc();
        bus.rom_ok = 0;
        #1 chk("rmid_scr_ok2", 32'(bus.scr_ok), 1);
        chk("rmid_scr_data2", bus.scr_data, 32'h77777777);

`ifdef JTKUNIO_ARB_STATS_EN
        bus.scr_cs = 0;
        rst_n = 0;
        cyc();
        chk("stat_rst", 32'(stat_maxwait), 0);
        rst_n = 1;
        bus.scr_cs = 1; bus.scr_addr = 17'h300; bus.obj_cs = 1; bus.obj_addr = 17'h301;
        repeat (6) cyc();
        bus.rom_ok = 1; bus.rom_data = 32'h300;
        cyc();
        bus.rom_ok = 0;
        cyc();
        chk("stat_maxwait", 32'(stat_maxwait), 7);
        cyc();
        bus.rom_ok = 1;
        cyc();
        bus.rom_ok = 0; bus.obj_cs = 0; bus.scr_cs = 0;
`endif

        bus.scr_cs = 0; bus.obj_cs = 0;
        rst_n = 0;
        cyc();
        rst_n = 1;
        auto_on();
        sw = 0; ow = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (bus.scr_ok) chk("rnd_scr_data", bus.scr_data, h(18'(bus.scr_addr)));
            if (bus.obj_ok) chk("rnd_obj_data", bus.obj_data, h(18'(bus.obj_addr) + OFS));
            sw = bus.scr_cs && !bus.scr_ok ? sw + 1 : sw;
            ow = bus.obj_cs && !bus.obj_ok ? ow + 1 : ow;
            if ((bus.scr_ok && sw > 0) || sw >= LIM) begin
                total++;
                if (sw >= LIM) begin bad++; $display("FAIL rnd_scr_wait: waited %0d limit %0d", sw, LIM); end
                sw = 0;
            end
            if ((bus.obj_ok && ow > 0) || ow >= LIM) begin
                total++;
                if (ow >= LIM) begin bad++; $display("FAIL rnd_obj_wait: waited %0d limit %0d", ow, LIM); end
                ow = 0;
            end
            if (!bus.scr_cs) sw = 0;
            if (!bus.obj_cs) ow = 0;
            r = $urandom_range(0, 15);
            if (!bus.scr_cs) begin
                if (r < 6) begin bus.scr_cs = 1; bus.scr_addr = pick(); end
            end else if (bus.scr_ok) begin
                if (r < 3) bus.scr_cs = 0;
                else if (r < 10) bus.scr_addr = pick();
            end else if (r == 0) bus.scr_addr = pick();
            r = $urandom_range(0, 15);
            if (!bus.obj_cs) begin
                if (r < 6) begin bus.obj_cs = 1; bus.obj_addr = pick(); end
            end else if (bus.obj_ok) begin
                if (r < 3) bus.obj_cs = 0;
                else if (r < 10) bus.obj_addr = pick();
            end else if (r == 0) bus.obj_addr = pick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
